// File: rtl/fcpu_pkg.sv
// Shared types and helpers for the fcpu front end.
// Branch predictor content:
//   BP_PHT_W / BP_GHR_W : default pattern-table index width and global-history width
//   bp_state_t          : predictor mode (table sweep vs. normal operation)
//   sat2_t              : 2-bit saturating direction counter, MSB = predict taken
//   sat2_inc / sat2_dec : saturating counter steps
package fcpu_pkg;

  localparam int BP_PHT_W = 6;
  localparam int BP_GHR_W = 4;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  typedef logic [1:0] sat2_t;

  // Value every counter holds after the table sweep: weakly not-taken.
  localparam sat2_t SAT2_WEAK_NT = 2'b01;

  function automatic sat2_t sat2_inc(input sat2_t ctr);
    return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
  endfunction

  function automatic sat2_t sat2_dec(input sat2_t ctr);
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/pattern_history_table.sv
// Pattern history table: 2**PHT_W saturating 2-bit counters.
// One combinational read port for lookups, one synchronous write port shared by
// the reset sweep (writes weakly not-taken) and commit training (saturating step).
// Ports:
//   clk          : clock
//   rd_index     : lookup index; rd_ctr returns that counter in the same cycle
//   sweep_en     : sweep write active; has priority over training
//   sweep_index  : entry written by the sweep
//   train_en     : commit training write
//   train_index  : entry trained
//   train_taken  : resolved direction to move the counter toward
module pattern_history_table
  import fcpu_pkg::*;
#(
  parameter int PHT_W = BP_PHT_W
) (
  input  logic             clk,
  input  logic [PHT_W-1:0] rd_index,
  output sat2_t            rd_ctr,
  input  logic             sweep_en,
  input  logic [PHT_W-1:0] sweep_index,
  input  logic             train_en,
  input  logic [PHT_W-1:0] train_index,
  input  logic             train_taken
);

  localparam int DEPTH = 1 << PHT_W;

  sat2_t            pht_r [DEPTH];
  sat2_t            train_old_s;
  sat2_t            wr_data_s;
  logic             wr_en_s;
  logic [PHT_W-1:0] wr_index_s;

  // Reads see the array before this cycle's write, giving read-before-write.
  assign rd_ctr      = pht_r[rd_index];
  assign train_old_s = pht_r[train_index];

  // Write mux: the sweep owns the port while it runs, otherwise commit training.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_index_s = sweep_index;
    wr_data_s  = SAT2_WEAK_NT;
    if (sweep_en) begin
      wr_en_s    = 1'b1;
      wr_index_s = sweep_index;
      wr_data_s  = SAT2_WEAK_NT;
    end else if (train_en) begin
      wr_en_s    = 1'b1;
      wr_index_s = train_index;
      wr_data_s  = train_taken ? sat2_inc(train_old_s) : sat2_dec(train_old_s);
    end else begin
      wr_en_s    = 1'b0;
    end
  end

  // Counter array storage; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pht_r[wr_index_s] <= wr_data_s;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Global-history (gshare) conditional-branch predictor.
// A lookup XORs the low PC bits with the speculative history to index the
// pattern table; the counter MSB is the predicted direction. Commits train the
// table and shift the architectural history; a misprediction restores the
// speculative history from the architectural one.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   q_valid/q_pc/q_ready     : lookup request handshake
//   p_valid/p_taken/p_index  : registered prediction, held until p_ready
//   p_ready                  : consumer accepts the prediction
//   commit_valid/commit_is_branch/commit_index/true_condition : commit training
//   pred_miss                : misprediction flush
module branch_predictor
  import fcpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PHT_W  = BP_PHT_W,
  parameter int GHR_W  = BP_GHR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_valid,
  input  logic [ADDR_W-1:0] q_pc,
  output logic              q_ready,
  output logic              p_valid,
  output logic              p_taken,
  output logic [PHT_W-1:0]  p_index,
  input  logic              p_ready,
  input  logic              commit_valid,
  input  logic              commit_is_branch,
  input  logic [PHT_W-1:0]  commit_index,
  input  logic              true_condition,
  input  logic              pred_miss
);

  bp_state_t        state_r;
  bp_state_t        state_next_s;
  logic [PHT_W-1:0] sweep_r;
  logic [GHR_W-1:0] spec_ghr_r;
  logic [GHR_W-1:0] arch_ghr_r;
  logic [GHR_W-1:0] arch_ghr_next_s;
  logic             p_valid_r;
  logic             p_taken_r;
  logic [PHT_W-1:0] p_index_r;

  logic [PHT_W-1:0] idx_s;
  sat2_t            ctr_s;
  logic             run_s;
  logic             accept_s;
  logic             train_s;
  logic             sweep_last_s;
  logic             unused_s;

  assign run_s        = (state_r == BP_RUN);
  // History is zero-extended to the index width before hashing.
  assign idx_s        = q_pc[PHT_W-1:0] ^ PHT_W'(spec_ghr_r);
  assign q_ready      = run_s & ~pred_miss & (~p_valid_r | p_ready);
  assign accept_s     = q_valid & q_ready;
  assign train_s      = run_s & commit_valid & commit_is_branch;
  assign sweep_last_s = (sweep_r == {PHT_W{1'b1}});
  assign unused_s     = ^{q_pc[ADDR_W-1:PHT_W], ctr_s[0]};

  pattern_history_table #(
    .PHT_W (PHT_W)
  ) u_pht (
    .clk         (clk),
    .rd_index    (idx_s),
    .rd_ctr      (ctr_s),
    .sweep_en    (state_r == BP_INIT),
    .sweep_index (sweep_r),
    .train_en    (train_s),
    .train_index (commit_index),
    .train_taken (true_condition)
  );

  // Architectural history after this cycle's commit; also the repair value on a miss.
  always_comb begin
    arch_ghr_next_s = arch_ghr_r;
    if (train_s) begin
      arch_ghr_next_s = {arch_ghr_r[GHR_W-2:0], true_condition};
    end else begin
      arch_ghr_next_s = arch_ghr_r;
    end
  end

  // Next-state logic: INIT leaves once the last entry has been swept.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BP_INIT: begin
        if (sweep_last_s) begin
          state_next_s = BP_RUN;
        end else begin
          state_next_s = BP_INIT;
        end
      end
      BP_RUN:  state_next_s = BP_RUN;
      default: state_next_s = BP_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BP_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sweep counter walks every entry while in INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_r <= '0;
    end else if (state_r == BP_INIT) begin
      sweep_r <= sweep_r + PHT_W'(1);
    end else begin
      sweep_r <= sweep_r;
    end
  end

  // History registers: a miss overrides any speculative shift (no lookup is accepted then).
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_r <= '0;
      arch_ghr_r <= '0;
    end else begin
      arch_ghr_r <= arch_ghr_next_s;
      if (pred_miss) begin
        spec_ghr_r <= arch_ghr_next_s;
      end else if (accept_s) begin
        spec_ghr_r <= {spec_ghr_r[GHR_W-2:0], ctr_s[1]};
      end else begin
        spec_ghr_r <= spec_ghr_r;
      end
    end
  end

  // Prediction output register; payload holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_r <= 1'b0;
      p_taken_r <= 1'b0;
      p_index_r <= '0;
    end else if (pred_miss) begin
      p_valid_r <= 1'b0;
    end else if (accept_s) begin
      p_valid_r <= 1'b1;
      p_taken_r <= ctr_s[1];
      p_index_r <= idx_s;
    end else if (p_ready) begin
      p_valid_r <= 1'b0;
    end else begin
      p_valid_r <= p_valid_r;
    end
  end

  assign p_valid = p_valid_r;
  assign p_taken = p_taken_r;
  assign p_index = p_index_r;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic [15:0] q_pc;
  logic        q_ready;
  logic        p_valid;
  logic        p_taken;
  logic [5:0]  p_index;
  logic        p_ready;
  logic        commit_valid;
  logic        commit_is_branch;
  logic [5:0]  commit_index;
  logic        true_condition;
  logic        pred_miss;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(16), .PHT_W(6), .GHR_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .q_valid          (q_valid),
    .q_pc             (q_pc),
    .q_ready          (q_ready),
    .p_valid          (p_valid),
    .p_taken          (p_taken),
    .p_index          (p_index),
    .p_ready          (p_ready),
    .commit_valid     (commit_valid),
    .commit_is_branch (commit_is_branch),
    .commit_index     (commit_index),
    .true_condition   (true_condition),
    .pred_miss        (pred_miss)
  );

  typedef struct {
    logic        rst;
    logic        qv;
    logic [15:0] pc;
    logic        pr;
    logic        cv;
    logic        cb;
    logic [5:0]  ci;
    logic        tc;
    logic        pm;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic       eqr;
    logic       epv;
    logic       ept;
    logic [5:0] epi;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, counters as 0..3, histories as 0..15.
  int pht_m [64];
  bit run_m   = 1'b0;
  int cnt_m   = 0;
  int spec_m  = 0;
  int arch_m  = 0;
  bit pv_m    = 1'b0;
  bit pt_m    = 1'b0;
  int pi_m    = 0;
  bit known_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic qv, input logic [15:0] pc,
                               input logic pr, input logic cv, input logic cb,
                               input logic [5:0] ci, input logic tc, input logic pm);
    vec_t v;
    v.rst = r; v.qv = qv; v.pc = pc; v.pr = pr; v.cv = cv;
    v.cb = cb; v.ci = ci; v.tc = tc; v.pm = pm;
    return v;
  endfunction

  function automatic row_t mkr(input vec_t v, input logic eqr, input logic epv,
                               input logic ept, input logic [5:0] epi);
    row_t r;
    r.v = v; r.eqr = eqr; r.epv = epv; r.ept = ept; r.epi = epi;
    return r;
  endfunction

  function automatic vec_t rndv();
    vec_t v;
    v.rst = 1'b0;
    v.qv  = ($urandom_range(0, 9) < 7);
    v.pc  = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 255)) << 8);
    v.pr  = ($urandom_range(0, 3) != 0);
    v.cv  = ($urandom_range(0, 1) == 1);
    v.cb  = ($urandom_range(0, 3) != 0);
    v.ci  = 6'($urandom_range(0, 15));
    v.tc  = ($urandom_range(0, 1) == 1);
    v.pm  = ($urandom_range(0, 9) == 0);
    return v;
  endfunction

  function automatic bit model_qr(input vec_t v);
    return run_m && !v.pm && (!pv_m || v.pr);
  endfunction

  task automatic model_tick(input vec_t v);
    int idx;
    bit tk;
    bit qr;
    if (v.rst) begin
      run_m = 1'b0; cnt_m = 0; spec_m = 0; arch_m = 0;
      pv_m = 1'b0; pt_m = 1'b0; pi_m = 0; known_m = 1'b1;
      foreach (pht_m[i]) pht_m[i] = 1;
      return;
    end
    qr  = model_qr(v);
    idx = int'(v.pc[5:0]) ^ spec_m;
    tk  = (pht_m[idx] >= 2);
    if (run_m && v.cv && v.cb) begin
      if (v.tc) pht_m[v.ci] = (pht_m[v.ci] >= 3) ? 3 : pht_m[v.ci] + 1;
      else      pht_m[v.ci] = (pht_m[v.ci] <= 0) ? 0 : pht_m[v.ci] - 1;
      arch_m = (arch_m * 2 + int'(v.tc)) % 16;
    end
    if (v.pm) begin
      spec_m = arch_m;
      pv_m   = 1'b0;
    end else if (v.qv && qr) begin
      spec_m = (spec_m * 2 + int'(tk)) % 16;
      pv_m   = 1'b1;
      pt_m   = tk;
      pi_m   = idx;
    end else if (v.pr) begin
      pv_m   = 1'b0;
    end
    if (!run_m) begin
      cnt_m++;
      if (cnt_m == 64) run_m = 1'b1;
    end
  endtask

  // One clock cycle: drive, check q_ready before the edge, check outputs after it.
  task automatic step(input vec_t v, output logic qr_seen);
    rst = v.rst; q_valid = v.qv; q_pc = v.pc; p_ready = v.pr;
    commit_valid = v.cv; commit_is_branch = v.cb; commit_index = v.ci;
    true_condition = v.tc; pred_miss = v.pm;
    #1;
    qr_seen = q_ready;
    if (known_m) chk("q_ready", q_ready, model_qr(v));
    model_tick(v);
    @(posedge clk);
    #1;
    chk("p_valid", p_valid, pv_m);
    chk("p_taken", p_taken, pt_m);
    chk("p_index", p_index, pi_m);
  endtask

  // Reset, then the sweep with lookups and (ignored) commits offered throughout.
  task automatic reset_and_init();
    logic qr;
    int   low_cycles;
    step(mkv(1'b1, 1'b1, 16'h0023, 1'b1, 1'b1, 1'b1, 6'h23, 1'b1, 1'b0), qr);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_taken", p_taken, 0);
    chk("rst_p_index", p_index, 0);
    low_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      step(mkv(1'b0, 1'b1, 16'h0023, 1'b1, 1'b1, 1'b1, 6'h23, 1'b1, 1'b0), qr);
      if (qr === 1'b0) low_cycles++;
    end
    chk("init_low_cycles", low_cycles, 64);
    q_valid = 1'b0; commit_valid = 1'b0;
    #1;
    chk("ready_after_init", q_ready, 1);
  endtask

  initial begin
    row_t tbl[$];
    logic qr;

    rst = 1'b1; q_valid = 1'b0; q_pc = '0; p_ready = 1'b1;
    commit_valid = 1'b0; commit_is_branch = 1'b0; commit_index = '0;
    true_condition = 1'b0; pred_miss = 1'b0;
    @(posedge clk);
    #1;

    reset_and_init();

    // Hand-derived sequence: training, history hash, miss repair, backpressure,
    // saturation and read-before-write.
    tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 1, 1, 6'h10, 1, 0), 1, 0, 0, 6'h00));
    tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 1, 1, 6'h10, 1, 0), 1, 0, 0, 6'h00));
    tbl.push_back(mkr(mkv(0, 1, 16'h0010, 1, 0, 0, 6'h00, 0, 0), 1, 1, 1, 6'h10));
    tbl.push_back(mkr(mkv(0, 1, 16'h0010, 1, 0, 0, 6'h00, 0, 1), 0, 0, 1, 6'h10));
    tbl.push_back(mkr(mkv(0, 1, 16'h0020, 1, 0, 0, 6'h00, 0, 0), 1, 1, 0, 6'h23));
    repeat (3) tbl.push_back(mkr(mkv(0, 1, 16'h0005, 0, 0, 0, 6'h00, 0, 0), 0, 1, 0, 6'h23));
    tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 0, 0, 6'h00, 0, 0), 1, 0, 0, 6'h23));
    repeat (5) tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 1, 1, 6'h05, 1, 0), 1, 0, 0, 6'h23));
    tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 1, 1, 6'h05, 0, 0), 1, 0, 0, 6'h23));
    tbl.push_back(mkr(mkv(0, 1, 16'h0003, 1, 0, 0, 6'h00, 0, 0), 1, 1, 1, 6'h05));
    repeat (4) tbl.push_back(mkr(mkv(0, 0, 16'h0000, 1, 1, 1, 6'h05, 0, 0), 1, 0, 1, 6'h05));
    tbl.push_back(mkr(mkv(0, 1, 16'h0008, 1, 0, 0, 6'h00, 0, 0), 1, 1, 0, 6'h05));
    tbl.push_back(mkr(mkv(0, 1, 16'h000A, 1, 1, 1, 6'h00, 1, 0), 1, 1, 0, 6'h00));
    tbl.push_back(mkr(mkv(0, 1, 16'h0004, 1, 0, 0, 6'h00, 0, 0), 1, 1, 1, 6'h00));

    foreach (tbl[i]) begin
      step(tbl[i].v, qr);
      chk($sformatf("tbl%0d_q_ready", i), qr, tbl[i].eqr);
      chk($sformatf("tbl%0d_p_valid", i), p_valid, tbl[i].epv);
      chk($sformatf("tbl%0d_p_taken", i), p_taken, tbl[i].ept);
      chk($sformatf("tbl%0d_p_index", i), p_index, tbl[i].epi);
    end

    for (int n = 0; n < 600; n++) begin
      step(rndv(), qr);
    end

    // Mid-run reset must drop the pending prediction and rerun the sweep.
    reset_and_init();

    for (int n = 0; n < 150; n++) begin
      step(rndv(), qr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
